// File: rtl/ctrl_pkg.sv
// Shared definitions for the contrast key controller: key FSM encoding and default timings.
package ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld,
    StRelease
  } key_state_e;

  localparam int unsigned DefaultDebounceCycles = 32'd50000;
  localparam int unsigned DefaultRepeatCycles   = 32'd12500000;

endpackage

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and auto-repeat request generator.
// Input is active-low; req is a one-cycle pulse on acceptance and on each repeat interval.
module key_debounce
  import ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned REPEAT_CYCLES   = DefaultRepeatCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic req
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RpW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DbW-1:0] DbMax  = DbW'(DEBOUNCE_CYCLES);
  localparam logic [RpW-1:0] RpLast = RpW'(REPEAT_CYCLES - 1);
  localparam logic [RpW-1:0] RpMax  = RpW'(REPEAT_CYCLES);

  logic key_s1_q, key_s2_q;
  logic pressed;
  key_state_e state_q, state_d;
  logic [DbW-1:0] db_q, db_d, db_inc;
  logic [RpW-1:0] rp_q, rp_d, rp_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= key_raw;
      key_s2_q <= key_s1_q;
    end
  end

  assign pressed = ~key_s2_q;
  assign db_inc  = (db_q == DbMax) ? db_q : db_q + DbW'(1);
  assign rp_inc  = (rp_q == RpMax) ? rp_q : rp_q + RpW'(1);

  // db counts consecutive cycles at the candidate level, including the cycle that left the
  // previous state, so acceptance lands on the DEBOUNCE_CYCLES-th stable cycle.
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    rp_d    = '0;
    req     = 1'b0;
    case (state_q)
      StIdle: begin
        if (pressed) begin
          state_d = StDebounce;
          db_d    = DbW'(1);
        end else begin
          db_d = '0;
        end
      end
      StDebounce: begin
        if (!pressed) begin
          state_d = StIdle;
          db_d    = '0;
        end else if (db_q >= DbLast) begin
          state_d = StHeld;
          db_d    = '0;
          req     = 1'b1;
        end else begin
          db_d = db_inc;
        end
      end
      StHeld: begin
        if (!pressed) begin
          state_d = StRelease;
          db_d    = DbW'(1);
        end else if (rp_q >= RpLast) begin
          req = 1'b1;
        end else begin
          rp_d = rp_inc;
        end
      end
      StRelease: begin
        if (pressed) begin
          state_d = StHeld;
          db_d    = '0;
        end else if (db_q >= DbLast) begin
          state_d = StIdle;
          db_d    = '0;
        end else begin
          db_d = db_inc;
        end
      end
      default: begin
        state_d = StIdle;
        db_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      db_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      rp_q    <= rp_d;
    end
  end

endmodule

// File: rtl/contrast_ctrl.sv
// Contrast up/down controller: debounced keys raise pending requests that are released
// as single-cycle strobes aligned to the frame boundary.
module contrast_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned REPEAT_CYCLES   = DefaultRepeatCycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  input  logic       frame_en,
  output logic       en,
  output logic       cinc,
  output logic       cdec
);

  logic sw_s1_q, sw_s2_q;
  logic inc_req, dec_req;
  logic inc_pend_q, inc_pend_d;
  logic dec_pend_q, dec_pend_d;
  logic unused_inputs;

  assign unused_inputs = ^{KEY[3:2], SW[9:2], SW[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1_q <= 1'b0;
      sw_s2_q <= 1'b0;
    end else begin
      sw_s1_q <= SW[1];
      sw_s2_q <= sw_s1_q;
    end
  end

  assign en = sw_s2_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_key_inc (
    .clk    (clk),
    .rst    (rst),
    .key_raw(KEY[0]),
    .req    (inc_req)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_key_dec (
    .clk    (clk),
    .rst    (rst),
    .key_raw(KEY[1]),
    .req    (dec_req)
  );

  assign cinc = frame_en & en & inc_pend_q & ~dec_pend_q;
  assign cdec = frame_en & en & dec_pend_q & ~inc_pend_q;

  // Every frame boundary consumes both flags (conflicts are dropped); a request landing on
  // that same cycle survives into the next frame.
  always_comb begin
    inc_pend_d = 1'b0;
    dec_pend_d = 1'b0;
    if (en) begin
      inc_pend_d = (inc_pend_q & ~frame_en) | inc_req;
      dec_pend_d = (dec_pend_q & ~frame_en) | dec_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_pend_q <= 1'b0;
      dec_pend_q <= 1'b0;
    end else begin
      inc_pend_q <= inc_pend_d;
      dec_pend_q <= dec_pend_d;
    end
  end

endmodule

// File: doc/contrast_ctrl.md
CONTRAST_CTRL -- requirements
Module: contrast_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: clock cycles a raw key level must hold stable before it is accepted (1 ms at 50 MHz).
REQ-002 Parameter REPEAT_CYCLES, default 12500000: clock cycles between auto-repeat requests while a key is held (250 ms at 50 MHz).
REQ-003 clk  in  1  sole clock; all state is rising-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 KEY  in  4  raw board push-buttons, active-low; KEY[0]=increase, KEY[1]=decrease, KEY[3:2] ignored.
REQ-006 SW  in  10  raw slide switches; SW[1] is the contrast-path enable, others ignored.
REQ-007 frame_en  in  1  one-cycle frame-boundary strobe from the video timing.
REQ-008 en  out  1  synchronized SW[1], drives contrast enable.
REQ-009 cinc  out  1  one-cycle increase-contrast strobe.
REQ-010 cdec  out  1  one-cycle decrease-contrast strobe.

Function
REQ-011 KEY[1:0] and SW[1] shall each pass through a 2-flop synchronizer before any other use.
REQ-012 Each of KEY[0] and KEY[1] shall run an independent FSM: IDLE -> DEBOUNCE on synced level low; DEBOUNCE -> HELD after DEBOUNCE_CYCLES consecutive low cycles; DEBOUNCE -> IDLE on any high cycle (counter cleared); HELD -> RELEASE on synced high; RELEASE -> IDLE after DEBOUNCE_CYCLES consecutive high cycles; RELEASE -> HELD on any low cycle.
REQ-013 The DEBOUNCE -> HELD transition shall raise exactly one request for that key.
REQ-014 In HELD, a repeat counter shall raise one further request every REPEAT_CYCLES cycles, counted from HELD entry; the counter clears on leaving HELD.
REQ-015 Requests shall set a per-direction pending flag; repeated requests before service shall not accumulate (flag stays 1).
REQ-016 cinc shall be 1 for exactly the single cycle in which frame_en=1, inc pending=1, dec pending=0 and en=1; the inc pending flag clears on that same edge.
REQ-017 cdec shall behave identically for the decrease direction.
REQ-018 If both flags are pending when frame_en=1, neither strobe shall fire, and both flags shall clear.
REQ-019 A request arriving in the same cycle as a serviced frame_en shall remain pending for the next frame.
REQ-020 While en=0 both pending flags shall be held clear and cinc=cdec=0.
REQ-021 cinc and cdec shall never both be 1 in the same cycle.
REQ-022 Counters shall saturate; they shall not wrap.
REQ-023 Latency from the first synced low of KEY to cinc/cdec = DEBOUNCE_CYCLES plus the wait to the next frame_en; en follows SW[1] by 2 cycles.

Reset
REQ-024 While rst=0: both FSMs in IDLE, all counters 0, pending flags 0, synchronizers in the released state (KEY=1, SW=0), en=0, cinc=0, cdec=0.
REQ-025 Reset asserted mid-press shall discard all debounce and pending state; after release, a still-held key shall re-enter via DEBOUNCE.

Structure
REQ-026 Package ctrl_pkg shall hold the key FSM state encoding (IDLE, DEBOUNCE, HELD, RELEASE) and the default DEBOUNCE_CYCLES and REPEAT_CYCLES constants.
REQ-027 Sub-module key_debounce (synchronizer, FSM, repeat counter, request output) shall be instantiated once per key; contrast_ctrl holds the pending flags, frame alignment and SW synchronizer.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20, frame_en every 50 cycles)
REQ-028 Reset, SW[1]=1, KEY[0] low 10 cycles -> en=1, exactly one cinc pulse, coincident with the next frame_en, cdec never 1.
REQ-029 KEY[1] bouncing low/high every 2 cycles for 20 cycles, then released -> no cdec pulse.
REQ-030 KEY[0] held 200 cycles -> cinc at each of the 4 frame_en strobes after debounce, never more than one per frame.
REQ-031 KEY[0] and KEY[1] both pressed within the same frame -> no strobe at the next frame_en, and no strobe at the following one.
REQ-032 SW[1]=0 with KEY[0] pressed -> cinc stays 0; SW[1] then set to 1 with no new press -> still no cinc.
REQ-033 rst pulsed low during DEBOUNCE of KEY[0] -> all outputs 0 immediately; key held after reset -> cinc only after a fresh 4-cycle debounce.
